data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the pipelined MIPS core. It receives the M-stage load/store requests the datapath drives: address `aluout_M`, store data `writedata_M`, and the `memwrite_M`/`memread_M` strobes. It serves each request from an internal word RAM after a programmable number of wait cycles, holding `stall_M` high until the access completes. `read_data_M` returns to the datapath's MEM/WB register.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; power of 2, 4..1024.
- `LATENCY`, 2: cycles `stall_M` is held per access; 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memread_M`  in  1  load request.
- `memwrite_M`  in  1  store request.
- `aluout_M`  in  32  byte address.
- `writedata_M`  in  32  store data.
- `read_data_M`  out  32  load data, registered.
- `stall_M`  out  1  pipeline hold; the core freezes PC, IF/ID, ID/EX and EX/MEM while high.
- `misalign_err`  out  1  sticky flag; set by any request with `aluout_M[1:0] != 0`.

## Operation
- A request is `req = memread_M | memwrite_M`.
- A request with both strobes high is a store. `read_data_M` keeps its previous value.
- Word index is `aluout_M[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses alias modulo `4*DEPTH`.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, `req` = 1, `LATENCY` = 1: go to DONE.
  - IDLE, `req` = 1, `LATENCY` > 1: go to WAIT, load `cnt = LATENCY-2`.
  - IDLE, `req` = 0: stay in IDLE.
  - WAIT, `req` = 0: abandon the access and return to IDLE. No write, `read_data_M` unchanged.
  - WAIT, `cnt` = 0: go to DONE.
  - WAIT, otherwise: decrement `cnt`.
  - DONE: go to IDLE unconditionally.
- `stall_M = req & (state != DONE)`. This is combinational and must not depend on `read_data_M`.
- Load data capture: `read_data_M <= mem[idx]` on the edge entering DONE. If the address is misaligned, 0 is captured instead.
- Store commit: `mem[idx] <= writedata_M` on the edge leaving DONE, which is the same edge on which the pipeline advances. Misaligned stores are dropped.
- `misalign_err` is set on the edge leaving IDLE with a misaligned request. Only reset clears it.
- The core holds `aluout_M`, `writedata_M` and the strobes stable while `stall_M` is high. The responder samples them again at DONE and does not latch them earlier.
- RAM contents are not cleared by reset. The bench initialises memory through stores.

## Timing
- Reset (asynchronous, `reset` low): state IDLE, `cnt` 0, `read_data_M` 0, `misalign_err` 0. `stall_M` evaluates to `req` as soon as reset is released.
- A reset assertion during WAIT or DONE aborts the access with no RAM write.
- Access latency: a request first seen at cycle t completes as follows.
  - `stall_M` is high for cycles t .. t+LATENCY-1.
  - DONE occurs in cycle t+LATENCY, with `stall_M` low and `read_data_M` valid.
  - The store commits at the end of cycle t+LATENCY.
- Back-to-back accesses: a new request at t+LATENCY+1 is seen in IDLE and starts a fresh count. There are no dead cycles beyond DONE.
- A load directly after a store to the same word returns the new data, because the store committed before the load's DONE capture.
- Throughput is one access per `LATENCY+1` cycles.

## Test plan
- **Reset state.** Hold `reset` low, toggle `clk`, drive `req` = 0 → `read_data_M` = 0, `stall_M` = 0, `misalign_err` = 0.
- **Store then load, `LATENCY` = 2.** Store 0xDEADBEEF to address 0x10, then load 0x10 → on each access `stall_M` is high exactly 2 cycles, DONE follows, and the load gives `read_data_M` = 0xDEADBEEF.
- **Aliasing, `DEPTH` = 64.** Store 0x12345678 to 0x104, then load 0x004 → 0x12345678.
- **Misaligned store.** Store 0xFFFFFFFF to 0x22, then load 0x20 → `misalign_err` = 1 from the cycle after the request, and the word at 0x20 is unchanged.
- **Abandoned request.** With `LATENCY` = 4, assert `memwrite_M` for 2 cycles, then drop it → FSM returns to IDLE, the target word is unchanged, and a following load shows a full 4-cycle stall.
- **Reset mid-access.** Pulse `reset` low during WAIT of a store of 0xA5A5A5A5 → `stall_M` reflects `req` immediately from IDLE, and the word is unchanged.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipelined MIPS core: serves M-stage loads and
// stores from a word RAM after LATENCY stall cycles, via an IDLE/WAIT/DONE FSM.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_M,
    input  logic        memwrite_M,
    input  logic [31:0] aluout_M,
    input  logic [31:0] writedata_M,
    output logic [31:0] read_data_M,
    output logic        stall_M,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [31:0]    r_mem [DEPTH];

    logic           w_req;
    logic           w_is_load;
    logic           w_misalign;
    logic           w_enter_done;
    logic [AW-1:0]  w_idx;
    logic           w_unused_addr;

    assign w_req         = memread_M | memwrite_M;
    assign w_is_load     = memread_M & ~memwrite_M;
    assign w_misalign    = aluout_M[1:0] != 2'b00;
    assign w_idx         = aluout_M[AW+1:2];
    // Upper address bits alias; they are deliberately not decoded.
    assign w_unused_addr = ^aluout_M[31:AW+2];

    assign stall_M       = w_req & (r_state != DONE);
    assign w_enter_done  = w_req & (((r_state == IDLE) && (LATENCY == 1)) ||
                                    ((r_state == WAIT) && (r_cnt == 4'd0)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            read_data_M  <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            if (w_enter_done && w_is_load)
                read_data_M <= w_misalign ? 32'd0 : r_mem[w_idx];

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_misalign)
                            misalign_err <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    // Dropping the strobes mid-wait abandons the access.
                    if (!w_req)
                        r_state <= IDLE;
                    else if (r_cnt == 4'd0)
                        r_state <= DONE;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset and only
    // stores initialise them. A reset forces r_state to IDLE, so no write
    // can commit while reset is asserted.
    always_ff @(posedge clk) begin
        if ((r_state == DONE) && memwrite_M && !w_misalign)
            r_mem[w_idx] <= writedata_M;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: two instances (LATENCY 2 and 4)
// driven with directed and random accesses, checked against an array model.
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT0  = 2;
    localparam int LAT1  = 4;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_i    [2];
    logic        wr_i    [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic [31:0] rdata_o [2];
    logic        stall_o [2];
    logic        err_o   [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_mem     [2][DEPTH];
    bit          m_written [2][DEPTH];
    logic [31:0] m_rd      [2];
    logic        m_err     [2];

    exp_t sb0[$];
    exp_t sb1[$];
    int   stall_cnt [2];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .memread_M(rd_i[0]), .memwrite_M(wr_i[0]),
        .aluout_M(addr_i[0]), .writedata_M(wdata_i[0]),
        .read_data_M(rdata_o[0]), .stall_M(stall_o[0]), .misalign_err(err_o[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut_l4 (
        .clk(clk), .reset(reset),
        .memread_M(rd_i[1]), .memwrite_M(wr_i[1]),
        .aluout_M(addr_i[1]), .writedata_M(wdata_i[1]),
        .read_data_M(rdata_o[1]), .stall_M(stall_o[1]), .misalign_err(err_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t q_front(input int d);
        return (d == 0) ? sb0[0] : sb1[0];
    endfunction

    function automatic exp_t q_pop(input int d);
        exp_t e;
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        return e;
    endfunction

    function automatic void q_push(input int d, input exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    // Architectural effect of one completed access: word-addressed RAM
    // modulo DEPTH, stores win over loads, misaligned data is dropped/zero.
    function automatic exp_t model(input int d, input logic rd, input logic wr,
                                   input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        int   idx;
        bit   mis;
        idx = int'((addr >> 2) % DEPTH);
        mis = (addr % 4) != 0;
        if (mis) m_err[d] = 1'b1;
        if (wr) begin
            if (!mis) begin
                m_mem[d][idx]     = data;
                m_written[d][idx] = 1'b1;
            end
        end else if (rd) begin
            m_rd[d] = mis ? 32'd0 : m_mem[d][idx];
        end
        e.rd  = m_rd[d];
        e.err = m_err[d];
        return e;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rd[d]  = 32'd0;
            m_err[d] = 1'b0;
        end
    endfunction

    // Issue one access (call just after a rising edge) and hold it until DONE.
    task automatic access(input int d, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
        int n;
        q_push(d, model(d, rd, wr, addr, data));
        rd_i[d]    = rd;
        wr_i[d]    = wr;
        addr_i[d]  = addr;
        wdata_i[d] = data;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_o[d] && n < 40);
        if (stall_o[d]) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d access timeout: stall_M still %b after %0d cycles", d, stall_o[d], n);
        end
        @(posedge clk);
        #1;
        rd_i[d] = 1'b0;
        wr_i[d] = 1'b0;
    endtask

    // Monitor: counts stall cycles and scores each DONE against the queue.
    initial begin
        exp_t cur;
        stall_cnt[0] = 0;
        stall_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!reset || !(rd_i[d] | wr_i[d])) begin
                    stall_cnt[d] = 0;
                end else if (stall_o[d]) begin
                    if (stall_cnt[d] >= 1 && q_size(d) > 0)
                        check($sformatf("dut%0d misalign_err during stall", d), err_o[d], q_front(d).err);
                    stall_cnt[d]++;
                end else begin
                    if (q_size(d) == 0) begin
                        check($sformatf("dut%0d unexpected completion", d), 32'd1, 32'd0);
                    end else begin
                        cur = q_pop(d);
                        check($sformatf("dut%0d stall cycles", d), stall_cnt[d], lat_of(d));
                        check($sformatf("dut%0d read_data_M", d), rdata_o[d], cur.rd);
                        check($sformatf("dut%0d misalign_err", d), err_o[d], cur.err);
                    end
                    stall_cnt[d] = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          upper;
        int          op;
        logic [31:0] a;
        logic        r;
        logic        w;

        for (int d = 0; d < 2; d++) begin
            rd_i[d] = 1'b0; wr_i[d] = 1'b0; addr_i[d] = 32'd0; wdata_i[d] = 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[d][i]     = 32'd0;
                m_written[d][i] = 1'b0;
            end
        end
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset read_data_M", d), rdata_o[d], 32'd0);
            check($sformatf("dut%0d reset stall_M", d), stall_o[d], 32'd0);
            check($sformatf("dut%0d reset misalign_err", d), err_o[d], 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Store then load, LATENCY 2
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        // Aliasing modulo 4*DEPTH
        access(0, 1'b0, 1'b1, 32'h104, 32'h12345678);
        access(0, 1'b1, 1'b0, 32'h004, 32'h0);
        // Misaligned store is dropped and sets the sticky flag
        access(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        access(0, 1'b0, 1'b1, 32'h22, 32'hFFFFFFFF);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0);

        // Abandoned store, LATENCY 4
        access(1, 1'b0, 1'b1, 32'h40, 32'h11111111);
        wr_i[1] = 1'b1; addr_i[1] = 32'h40; wdata_i[1] = 32'h22222222;
        repeat (2) @(posedge clk);
        #1;
        wr_i[1] = 1'b0;
        @(posedge clk);
        #1;
        access(1, 1'b1, 1'b0, 32'h40, 32'h0);

        // Reset mid-access
        access(1, 1'b0, 1'b1, 32'h50, 32'h33333333);
        wr_i[1] = 1'b1; addr_i[1] = 32'h50; wdata_i[1] = 32'hA5A5A5A5;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("stall_M follows req in reset", stall_o[1], 32'd1);
        check("read_data_M cleared by reset", rdata_o[1], 32'd0);
        wr_i[1] = 1'b0;
        #1;
        check("stall_M low with no req", stall_o[1], 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        access(1, 1'b1, 1'b0, 32'h50, 32'h0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);

        // Randomized traffic, occasionally back-to-back
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                idx   = int'($urandom_range(0, DEPTH - 1));
                upper = int'($urandom_range(0, 15));
                a     = 32'(upper * DEPTH * 4 + idx * 4);
                if ($urandom_range(0, 7) == 0)
                    a = a + 32'($urandom_range(1, 3));
                op = int'($urandom_range(0, 2));
                r  = (op != 1);
                w  = (op != 0);
                if (r && !w && (a % 4) == 0 && !m_written[d][idx]) begin
                    r = 1'b0;
                    w = 1'b1;
                end
                access(d, r, w, a, $urandom);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (3) @(posedge clk);
        check("dut0 scoreboard drained", sb0.size(), 32'd0);
        check("dut1 scoreboard drained", sb1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
